// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}; every pin is active-low.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  typedef struct packed {
    logic [3:0] bcd;
    logic       dp;
  } snap_t;

  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;
  localparam logic DP_ON   = 1'b0;
  localparam logic DP_OFF  = 1'b1;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Codes 10..15 render as a dark digit.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Define DISP_SCAN_BLINK_EN to add per-digit blinking (i_blink_mask).
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SOURCE_CLOCK = 100_000_000,
  parameter int SCAN_FREQ    = 400,
  parameter int NUM_DIGITS   = 6,
  parameter int BLANK_CYCLES = 1000
`ifdef DISP_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 33
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic [NUM_DIGITS-1:0]   i_dp,
`ifdef DISP_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int TICK_MAX = SOURCE_CLOCK / SCAN_FREQ;
  localparam int CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_MAX - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0] DIG_LAST = 3'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= TICK_MAX) begin : g_bad_blank
    $error("disp_scan_ctrl: BLANK_CYCLES out of range");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("disp_scan_ctrl: NUM_DIGITS out of range");
  end

  scan_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] digit, digit_nxt;
  snap_t snap, snap_nxt;
  logic load;
  logic hide;
  logic frame_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0] seg_nxt, seg_dec;
  logic dp_nxt;

  bcd_to_seg7 u_dec (
    .bcd (snap.bcd),
    .seg (seg_dec)
  );

  // Enable dominates; a fresh enable always restarts at digit 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    digit_nxt = digit;
    load      = 1'b0;
    priority case (1'b1)
      !i_en: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
        digit_nxt = '0;
      end
      (state == ST_OFF): begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        digit_nxt = '0;
        load      = 1'b1;
      end
      (state == ST_BLANK): begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == BLK_LAST) state_nxt = ST_DRIVE;
      end
      default: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          digit_nxt = (digit == DIG_LAST) ? 3'd0 : digit + 3'd1;
          load      = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    snap_nxt = snap;
    if (load) begin
      snap_nxt.bcd = i_bcd[int'(digit_nxt)*4 +: 4];
      snap_nxt.dp  = i_dp[digit_nxt];
    end
  end

  assign frame_nxt = load && (digit_nxt == 3'd0);

  always_comb begin
    an_nxt  = {NUM_DIGITS{AN_OFF}};
    seg_nxt = SEG_BLANK;
    dp_nxt  = DP_OFF;
    if (state_nxt == ST_DRIVE) begin
      if (!hide) an_nxt = ~(NUM_DIGITS'(1) << digit_nxt);
      seg_nxt = seg_dec;
      dp_nxt  = snap.dp ? DP_ON : DP_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_OFF;
      cnt     <= '0;
      digit   <= '0;
      snap    <= '{bcd: 4'hF, dp: 1'b0};
      o_an    <= {NUM_DIGITS{AN_OFF}};
      o_seg   <= SEG_BLANK;
      o_dp    <= DP_OFF;
      o_frame <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      digit   <= digit_nxt;
      snap    <= snap_nxt;
      o_an    <= an_nxt;
      o_seg   <= seg_nxt;
      o_dp    <= dp_nxt;
      o_frame <= frame_nxt;
    end
  end

`ifdef DISP_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic phase;
  logic mask_snap;

  // Phase flips once BLINK_FRAMES whole frames have been shown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcnt      <= '0;
      phase     <= 1'b0;
      mask_snap <= 1'b0;
    end else begin
      if (load) mask_snap <= i_blink_mask[digit_nxt];
      if (frame_nxt) begin
        if (fcnt == FW'(BLINK_FRAMES)) begin
          fcnt  <= FW'(1);
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  assign hide = phase & mask_snap;
`else
  assign hide = 1'b0;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with TICK_MAX=10, BLANK_CYCLES=2.
// Blink steps run when DISP_SCAN_BLINK_EN is defined.
module tb_disp_scan_ctrl;

  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] bcd;
  logic [5:0]  dp;
`ifdef DISP_SCAN_BLINK_EN
  logic [5:0]  mask;
`endif
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dpo;
  logic        frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .SOURCE_CLOCK (100),
    .SCAN_FREQ    (10),
    .NUM_DIGITS   (6),
    .BLANK_CYCLES (2)
`ifdef DISP_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_bcd        (bcd),
    .i_dp         (dp),
`ifdef DISP_SCAN_BLINK_EN
    .i_blink_mask (mask),
`endif
    .o_an         (an),
    .o_seg        (seg),
    .o_dp         (dpo),
    .o_frame      (frame)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp,
                         input logic e_fr);
    chk({tag, ".an"}, {2'b0, an}, {2'b0, e_an});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
    chk({tag, ".dp"}, {7'b0, dpo}, {7'b0, e_dp});
    chk({tag, ".frame"}, {7'b0, frame}, {7'b0, e_fr});
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    bcd = 24'h123456;
    dp  = 6'b000000;
`ifdef DISP_SCAN_BLINK_EN
    mask = 6'b000000;
`endif
    step(3);
    chk_out("reset", 6'h3F, SB, 1'b1, 1'b0);
    rst = 1'b0;
    en  = 1'b1;

    // steady scan: slot k begins at edge 1+10k
    step(1);
    chk_out("e1_blank0", 6'h3F, SB, 1'b1, 1'b1);
    step(1);
    chk_out("e2_blank0", 6'h3F, SB, 1'b1, 1'b0);
    step(1);
    chk_out("e3_drive0", 6'h3E, S6, 1'b1, 1'b0);
    step(7);
    chk_out("e10_drive0", 6'h3E, S6, 1'b1, 1'b0);
    step(1);
    chk_out("e11_blank1", 6'h3F, SB, 1'b1, 1'b0);
    step(2);
    chk_out("e13_drive1", 6'h3D, S5, 1'b1, 1'b0);
    step(47);
    chk("e60_frame", {7'b0, frame}, 8'h00);
    step(1);
    chk_out("e61_frame", 6'h3F, SB, 1'b1, 1'b1);

    // invalid code on digit 2 plus its decimal point
    bcd = 24'h123B56;
    dp  = 6'b000100;
    step(2);
    chk_out("e63_drive0", 6'h3E, S6, 1'b1, 1'b0);
    step(20);
    chk_out("e83_bad2", 6'h3B, SB, 1'b0, 1'b0);
    step(7);
    chk_out("e90_bad2", 6'h3B, SB, 1'b0, 1'b0);
    step(1);
    chk_out("e91_blank3", 6'h3F, SB, 1'b1, 1'b0);
    step(2);
    chk_out("e93_drive3", 6'h37, S3, 1'b1, 1'b0);

    // digit 0 nibble changes at cnt=5 of its drive
    step(33);
    chk_out("e126_cnt5", 6'h3E, S6, 1'b1, 1'b0);
    bcd = 24'h123B59;
    step(1);
    chk_out("e127_hold", 6'h3E, S6, 1'b1, 1'b0);
    step(3);
    chk_out("e130_hold", 6'h3E, S6, 1'b1, 1'b0);
    step(53);
    chk_out("e183_new", 6'h3E, S9, 1'b1, 1'b0);

    // enable drop during digit 3 drive, then restart
    step(32);
    chk_out("e215_drive3", 6'h37, S3, 1'b1, 1'b0);
    en = 1'b0;
    step(1);
    chk_out("en_off1", 6'h3F, SB, 1'b1, 1'b0);
    step(2);
    chk_out("en_off3", 6'h3F, SB, 1'b1, 1'b0);
    en = 1'b1;
    step(1);
    chk_out("en_on1", 6'h3F, SB, 1'b1, 1'b1);
    step(2);
    chk_out("en_on3", 6'h3E, S9, 1'b1, 1'b0);

    // reset during digit 4 drive
    step(42);
    chk_out("drive4", 6'h2F, S2, 1'b1, 1'b0);
    rst = 1'b1;
    step(1);
    chk_out("rst_mid", 6'h3F, SB, 1'b1, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);
    chk_out("rst_rel1", 6'h3F, SB, 1'b1, 1'b1);
    step(2);
    chk_out("rst_rel3", 6'h3E, S9, 1'b1, 1'b0);

`ifdef DISP_SCAN_BLINK_EN
    // blink digit 0 with two-frame half-period
    rst  = 1'b1;
    mask = 6'b000001;
    step(1);
    rst = 1'b0;
    step(3);
    chk("blink_f0", {2'b0, an}, 8'h3E);
    step(60);
    chk("blink_f1", {2'b0, an}, 8'h3E);
    step(60);
    chk("blink_f2", {2'b0, an}, 8'h3F);
    chk("blink_f2_seg", {1'b0, seg}, {1'b0, S9});
    step(10);
    chk("blink_f2_d1", {2'b0, an}, 8'h3D);
    step(50);
    chk("blink_f3", {2'b0, an}, 8'h3F);
    step(60);
    chk("blink_f4", {2'b0, an}, 8'h3E);
    step(60);
    chk("blink_f5", {2'b0, an}, 8'h3E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
